// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, mode FSM and count-tick prescaler for the BCD stopwatch.
// Define STOPWATCH_CTRL_BLINK_EN to drive blink_o at 2 Hz on the digit under edit in SET.
module stopwatch_ctrl #(
    parameter int CLK_FREQ_HZ     = 100000000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NDIGITS         = 4
) (
    input  logic       clk100_i,
    input  logic       rstn_i,
    input  logic       start_stop_i,
    input  logic       set_i,
    input  logic       change_i,
    output logic       tick_o,
    output logic       run_o,
    output logic       set_mode_o,
    output logic [1:0] digit_sel_o,
    output logic       inc_o,
    output logic       clear_o,
    output logic       blink_o
);
    localparam int PMAX = CLK_FREQ_HZ / TICK_HZ - 1;
    localparam int PW = $clog2(PMAX + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] DMAX = 2'(NDIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, SET} state_t;

    // bit 0 = start/stop, bit 1 = set, bit 2 = change; all active-high after inversion
    logic [2:0] sync1, sync2, level, level_d, press;
    logic [DW-1:0] db_cnt [3];
    logic ev_start, ev_set, ev_change;

    state_t state, state_n;
    logic [1:0] dsel, dsel_n;
    logic [PW-1:0] pre, pre_n;
    logic tick_n, inc_n, clr_n;

    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
        end else begin
            sync1   <= ~{change_i, set_i, start_stop_i};
            sync2   <= sync1;
            level_d <= level;
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[k]  <= sync2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign press     = level & ~level_d;
    assign ev_start  = press[0];
    assign ev_set    = press[1] & ~press[0];
    assign ev_change = press[2] & ~|press[1:0];

    always_comb begin
        state_n = state;
        dsel_n  = dsel;
        pre_n   = pre;
        tick_n  = 1'b0;
        inc_n   = 1'b0;
        clr_n   = 1'b0;
        case (state)
            IDLE: begin
                if (ev_start) begin
                    state_n = RUN;
                end else if (ev_set) begin
                    state_n = SET;
                    dsel_n  = '0;
                    pre_n   = '0;
                end else if (ev_change) begin
                    clr_n = 1'b1;
                end
            end
            RUN: begin
                // the prescaler keeps counting on the exit edge, but that edge never ticks
                pre_n  = (pre == PW'(PMAX)) ? '0 : pre + 1'b1;
                tick_n = (pre == PW'(PMAX)) && !ev_start;
                if (ev_start) state_n = PAUSE;
            end
            PAUSE: begin
                if (ev_start) begin
                    state_n = RUN;
                end else if (ev_set) begin
                    state_n = SET;
                    dsel_n  = '0;
                    pre_n   = '0;
                end else if (ev_change) begin
                    state_n = IDLE;
                    clr_n   = 1'b1;
                    pre_n   = '0;
                end
            end
            SET: begin
                if (ev_start) begin
                    state_n = PAUSE;
                    dsel_n  = '0;
                end else if (ev_set) begin
                    state_n = (dsel == DMAX) ? PAUSE : SET;
                    dsel_n  = (dsel == DMAX) ? 2'd0 : dsel + 2'd1;
                end else if (ev_change) begin
                    inc_n = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            dsel    <= '0;
            pre     <= '0;
            tick_o  <= 1'b0;
            inc_o   <= 1'b0;
            clear_o <= 1'b0;
        end else begin
            state   <= state_n;
            dsel    <= dsel_n;
            pre     <= pre_n;
            tick_o  <= tick_n;
            inc_o   <= inc_n;
            clear_o <= clr_n;
        end
    end

    assign run_o       = (state == RUN);
    assign set_mode_o  = (state == SET);
    assign digit_sel_o = dsel;

`ifdef STOPWATCH_CTRL_BLINK_EN
    localparam int BHALF = CLK_FREQ_HZ / 4;
    localparam int BW = $clog2(BHALF + 1);
    logic [BW-1:0] blink_cnt;

    // any edit or SET entry/exit restarts the half-period with the digit visible
    always_ff @(posedge clk100_i) begin
        if (!rstn_i || state != SET || state_n != SET || inc_n || dsel_n != dsel) begin
            blink_cnt <= '0;
            blink_o   <= 1'b0;
        end else if (blink_cnt == BW'(BHALF - 1)) begin
            blink_cnt <= '0;
            blink_o   <= ~blink_o;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    assign blink_o = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed button sequences with a queued expectation scoreboard.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
    localparam logic [2:0] ST = 3'b001, SE = 3'b010, CH = 3'b100;

    logic clk100 = 1'b0, rstn = 1'b0;
    logic start_stop = 1'b1, set_b = 1'b1, change = 1'b1;
    logic tick, run, set_mode, inc, clear, blink;
    logic [1:0] digit_sel;

    typedef struct {
        logic r; logic s; logic [1:0] d; logic i; logic c; logic t; int gap;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int vectors = 0, miscompares = 0, since = 0;
    logic mon_on = 1'b0, first = 1'b1;
    logic [3:0] prev = '0, cur;

    always #5 clk100 = ~clk100;

    stopwatch_ctrl #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4), .NDIGITS(4)) dut (
        .clk100_i(clk100), .rstn_i(rstn), .start_stop_i(start_stop), .set_i(set_b),
        .change_i(change), .tick_o(tick), .run_o(run), .set_mode_o(set_mode),
        .digit_sel_o(digit_sel), .inc_o(inc), .clear_o(clear), .blink_o(blink)
    );

    task automatic push(input logic r, input logic s, input logic [1:0] d, input logic i,
                        input logic c, input logic t, input int gap);
        exp_t x;
        x.r = r; x.s = s; x.d = d; x.i = i; x.c = c; x.t = t; x.gap = gap;
        q.push_back(x);
    endtask

    // RUN entry, n ticks (first after 'fst' cycles, then every 10), then PAUSE 'last' cycles later
    task automatic push_run(input int fst, input int n, input int last);
        push(1, 0, 0, 0, 0, 0, -1);
        for (int k = 0; k < n; k++) push(1, 0, 0, 0, 0, 1, k == 0 ? fst : 10);
        if (last >= 0) push(0, 0, 0, 0, 0, 0, last);
    endtask

    task automatic btn(input logic [2:0] m, input int hold, input int settle);
        {change, set_b, start_stop} = ~m;
        repeat (hold) @(negedge clk100);
        {change, set_b, start_stop} = 3'b111;
        repeat (settle) @(negedge clk100);
    endtask

    task automatic press(input logic [2:0] m);
        btn(m, 6, 14);
    endtask

    always @(negedge clk100) begin
        if (mon_on) begin
            cur = {run, set_mode, digit_sel};
            since++;
            if (first || inc || clear || tick || cur != prev) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected event at %0t: r%0b s%0b d%0d i%0b c%0b t%0b, want no event",
                             $time, run, set_mode, digit_sel, inc, clear, tick);
                end else begin
                    e = q.pop_front();
                    if ({run, set_mode, digit_sel, inc, clear, tick, blink} !== {e.r, e.s, e.d, e.i, e.c, e.t, 1'b0}
                        || (e.gap >= 0 && since != e.gap)) begin
                        miscompares++;
                        $display("FAIL event %0d at %0t: got r%0b s%0b d%0d i%0b c%0b t%0b b%0b gap %0d, want r%0b s%0b d%0d i%0b c%0b t%0b b0 gap %0d",
                                 vectors, $time, run, set_mode, digit_sel, inc, clear, tick, blink, since,
                                 e.r, e.s, e.d, e.i, e.c, e.t, e.gap);
                    end
                end
                prev  = cur;
                since = 0;
                first = 1'b0;
            end
        end
    end

    initial begin
        push(0, 0, 0, 0, 0, 0, -1);
        repeat (3) @(negedge clk100);
        rstn = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(negedge clk100);
        // run, pause mid-count, resume from the held prescaler value
        push_run(10, 4, 3);
        press(ST);
        repeat (23) @(negedge clk100);
        press(ST);
        repeat (17) @(negedge clk100);
        push_run(7, 6, 3);
        press(ST);
        press(SE);
        press(CH);
        press(ST);
        // clear from PAUSE returns to IDLE with the prescaler zeroed
        push(0, 0, 0, 0, 1, 0, -1);
        press(CH);
        btn(ST, 3, 10);
        push_run(10, 1, 10);
        press(ST);
        press(ST);
        // digit editing
        push(0, 1, 0, 0, 0, 0, 20);
        press(SE);
        for (int k = 0; k < 3; k++) begin
            push(0, 1, 0, 1, 0, 0, 20);
            press(CH);
        end
        push(0, 1, 1, 0, 0, 0, 20);
        press(SE);
        push(0, 1, 1, 1, 0, 0, 20);
        press(CH);
        push(0, 1, 2, 0, 0, 0, 20);
        press(SE);
        push(0, 1, 3, 0, 0, 0, 20);
        press(SE | CH);
        push(0, 0, 0, 0, 0, 0, 20);
        press(SE);
        push_run(10, 1, 10);
        press(ST | SE);
        press(ST);
        push(0, 1, 0, 0, 0, 0, 20);
        press(SE);
        // reset in SET with start held: outputs clear, then one start event
        push(0, 0, 0, 0, 0, 0, 16);
        push_run(10, 1, -1);
        start_stop = 1'b0;
        repeat (2) @(negedge clk100);
        rstn = 1'b0;
        @(negedge clk100);
        rstn = 1'b1;
        repeat (9) @(negedge clk100);
        start_stop = 1'b1;
        repeat (13) @(negedge clk100);
        mon_on = 1'b0;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d expected events never seen, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
